na_be_wb_slave: RTL and testbench

// - Wishbone classic slave: the best-effort NA endpoint window that the DI-NA bridge and CPU read from and write to.
// - Writes assemble a packet in the TX FIFO. The packet goes to the NoC only once complete (store-and-forward).
// - Incoming NoC flits collect in the RX FIFO. irq signals that a complete packet is waiting.

---
 rtl/na_wb_pkg.sv | 24 ++
 rtl/na_flit_fifo.sv | 58 +++++
 rtl/na_be_wb_slave.sv | 261 ++++++++++++++++++++++++++
 tb/tb_na_be_wb_slave.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/na_wb_pkg.sv
// Register map and CTRL bit layout of the best-effort NA Wishbone window.
// Also used as the reference for the driver headers.
package na_wb_pkg;

  // Word offsets, decoded from wb_adr_i[4:2]
  localparam logic [2:0] ADDR_TX_DATA = 3'd0;  // W: push flit, last=0
  localparam logic [2:0] ADDR_TX_LAST = 3'd1;  // W: push flit, last=1 (commit)
  localparam logic [2:0] ADDR_RX_DATA = 3'd2;  // R: pop RX head flit
  localparam logic [2:0] ADDR_RX_STAT = 3'd3;  // R: {head.last, pkts, flits}
  localparam logic [2:0] ADDR_TX_FREE = 3'd4;  // R: free TX entries
  localparam logic [2:0] ADDR_CTRL    = 3'd5;  // R/W: enable, irq_en

  // CTRL register bit positions
  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;

  // Outcome of a decoded Wishbone request
  typedef enum logic [1:0] {
    RSP_NONE,
    RSP_ACK,
    RSP_ERR
  } wb_rsp_e;

endpackage

// File: rtl/na_flit_fifo.sv
// Synchronous flit FIFO (flit + last bit), power-of-2 depth.
// Push while full and pop while empty are ignored.
module na_flit_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // Storage write
  // NOTE: the array has no reset; pointers and count define validity, and a reset would turn it into flops.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH
  // NOTE: sequential state uses non-blocking assignments so every reader sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/na_be_wb_slave.sv
// Best-effort NA endpoint: Wishbone classic slave with a store-and-forward
// TX packet FIFO towards the NoC and an RX FIFO with a packet-pending irq.
module na_be_wb_slave
  import na_wb_pkg::*;
#(
  parameter int FLIT_WIDTH  = 32,
  parameter int TX_DEPTH    = 16,
  parameter int RX_DEPTH    = 16,
  parameter int MAX_PKT_LEN = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           wb_adr_i,
  input  logic [FLIT_WIDTH-1:0] wb_dat_i,
  input  logic [3:0]            wb_sel_i,
  input  logic                  wb_we_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  output logic [FLIT_WIDTH-1:0] wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic [FLIT_WIDTH-1:0] noc_out_flit,
  output logic                  noc_out_last,
  output logic                  noc_out_valid,
  input  logic                  noc_out_ready,
  input  logic [FLIT_WIDTH-1:0] noc_in_flit,
  input  logic                  noc_in_last,
  input  logic                  noc_in_valid,
  output logic                  noc_in_ready,
  output logic                  irq
);

  localparam int FW  = FLIT_WIDTH;
  localparam int TCW = $clog2(TX_DEPTH) + 1;
  localparam int RCW = $clog2(RX_DEPTH) + 1;
  localparam int PW  = $clog2(MAX_PKT_LEN);

  // Registered state
  logic           r_enable;
  logic           r_irq_en;
  logic           r_ack;
  logic           r_err;
  logic           r_irq;
  logic [FW-1:0]  r_dat;
  logic [TCW-1:0] r_tx_pkts;
  logic [RCW-1:0] r_rx_pkts;
  logic [PW-1:0]  r_partial;

  // FIFO interface
  logic           w_tx_push;
  logic           w_tx_last_in;
  logic           w_tx_pop;
  logic           w_tx_full;
  logic           w_tx_empty;
  logic [FW:0]    w_tx_head;
  logic [TCW-1:0] w_tx_count;
  logic           w_rx_push;
  logic           w_rx_pop;
  logic           w_rx_full;
  logic           w_rx_empty;
  logic [FW:0]    w_rx_head;
  logic [RCW-1:0] w_rx_count;

  // Decode
  logic           w_req;
  logic [2:0]     w_addr;
  wb_rsp_e        w_rsp;
  logic           w_ctrl_wr;
  logic [FW-1:0]  w_rdata;
  logic           w_rx_head_last;
  logic [31:0]    w_rx_stat;
  logic [TCW-1:0] w_tx_free;
  logic           w_tx_commit;
  logic           w_tx_depart;
  logic           w_rx_pkt_in;
  logic           w_rx_pkt_out;
  logic           w_unused;

  // Address bits outside [4:2], byte selects and TX empty are not needed
  assign w_unused = &{1'b0, wb_sel_i, wb_adr_i[31:5], wb_adr_i[1:0], w_tx_empty};

  // A new request is one not already being answered this cycle
  assign w_req  = wb_cyc_i & wb_stb_i & ~(r_ack | r_err);
  assign w_addr = wb_adr_i[4:2];

  assign w_rx_head_last = ~w_rx_empty & w_rx_head[FW];
  assign w_rx_stat      = {w_rx_head_last, 15'(r_rx_pkts), 16'(w_rx_count)};
  assign w_tx_free      = TCW'(TX_DEPTH) - w_tx_count;

  // Request decode: choose ack/err and the single side effect of the access
  // NOTE: every output gets a default first, so no path leaves a latch behind.
  always_comb begin
    w_rsp        = RSP_NONE;
    w_tx_push    = 1'b0;
    w_tx_last_in = 1'b0;
    w_rx_pop     = 1'b0;
    w_ctrl_wr    = 1'b0;
    w_rdata      = '0;
    if (w_req) begin
      w_rsp = RSP_ERR;
      case (w_addr)
        ADDR_TX_DATA: begin
          // Leave room for the closing TX_LAST within MAX_PKT_LEN
          if (wb_we_i && r_enable && !w_tx_full &&
              (r_partial < PW'(MAX_PKT_LEN - 1))) begin
            w_rsp     = RSP_ACK;
            w_tx_push = 1'b1;
          end
        end
        ADDR_TX_LAST: begin
          if (wb_we_i && r_enable && !w_tx_full) begin
            w_rsp        = RSP_ACK;
            w_tx_push    = 1'b1;
            w_tx_last_in = 1'b1;
          end
        end
        ADDR_RX_DATA: begin
          if (!wb_we_i && !w_rx_empty) begin
            w_rsp    = RSP_ACK;
            w_rx_pop = 1'b1;
            w_rdata  = w_rx_head[FW-1:0];
          end
        end
        ADDR_RX_STAT: begin
          if (!wb_we_i) begin
            w_rsp   = RSP_ACK;
            w_rdata = FW'(w_rx_stat);
          end
        end
        ADDR_TX_FREE: begin
          if (!wb_we_i) begin
            w_rsp   = RSP_ACK;
            w_rdata = FW'(w_tx_free);
          end
        end
        ADDR_CTRL: begin
          w_rsp = RSP_ACK;
          if (wb_we_i) begin
            w_ctrl_wr = 1'b1;
          end else begin
            w_rdata[CTRL_ENABLE_BIT] = r_enable;
            w_rdata[CTRL_IRQ_EN_BIT] = r_irq_en;
          end
        end
        default: w_rsp = RSP_ERR;
      endcase
    end
  end

  // One-cycle ack/err pulse with read data; data is zero unless a read acks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= (w_rsp == RSP_ACK);
      r_err <= (w_rsp == RSP_ERR);
      r_dat <= w_rdata;
    end
  end

  // CTRL register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enable <= 1'b0;
      r_irq_en <= 1'b0;
    end else if (w_ctrl_wr) begin
      r_enable <= wb_dat_i[CTRL_ENABLE_BIT];
      r_irq_en <= wb_dat_i[CTRL_IRQ_EN_BIT];
    end
  end

  // Flits already written into the still-open TX packet
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_partial <= '0;
    else if (w_tx_push)  r_partial <= w_tx_last_in ? '0 : r_partial + 1'b1;
  end

  assign w_tx_commit = w_tx_push & w_tx_last_in;
  assign w_tx_depart = w_tx_pop & w_tx_head[FW];

  // Committed TX packets; only these are visible to the NoC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_pkts <= '0;
    end else begin
      case ({w_tx_commit, w_tx_depart})
        2'b10:   r_tx_pkts <= r_tx_pkts + 1'b1;
        2'b01:   r_tx_pkts <= r_tx_pkts - 1'b1;
        default: r_tx_pkts <= r_tx_pkts;
      endcase
    end
  end

  assign w_rx_pkt_in  = w_rx_push & noc_in_last;
  assign w_rx_pkt_out = w_rx_pop & w_rx_head_last;

  // Complete RX packets waiting in the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_pkts <= '0;
    end else begin
      case ({w_rx_pkt_in, w_rx_pkt_out})
        2'b10:   r_rx_pkts <= r_rx_pkts + 1'b1;
        2'b01:   r_rx_pkts <= r_rx_pkts - 1'b1;
        default: r_rx_pkts <= r_rx_pkts;
      endcase
    end
  end

  // Packet-pending interrupt, level, one cycle behind the packet count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_irq <= 1'b0;
    else        r_irq <= r_irq_en & (r_rx_pkts != '0);
  end

  // NoC side: a flit leaves only while a committed packet is queued
  assign noc_out_valid = (r_tx_pkts != '0);
  assign noc_out_flit  = noc_out_valid ? w_tx_head[FW-1:0] : '0;
  assign noc_out_last  = noc_out_valid & w_tx_head[FW];
  assign w_tx_pop      = noc_out_valid & noc_out_ready;
  assign noc_in_ready  = r_enable & ~w_rx_full;
  assign w_rx_push     = noc_in_valid & noc_in_ready;

  assign wb_ack_o = r_ack;
  assign wb_err_o = r_err;
  assign wb_dat_o = r_dat;
  assign irq      = r_irq;

  na_flit_fifo #(
    .WIDTH (FW + 1),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_tx_push),
    .i_data  ({w_tx_last_in, wb_dat_i}),
    .i_pop   (w_tx_pop),
    .o_data  (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count (w_tx_count)
  );

  na_flit_fifo #(
    .WIDTH (FW + 1),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_rx_push),
    .i_data  ({noc_in_last, noc_in_flit}),
    .i_pop   (w_rx_pop),
    .o_data  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_count (w_rx_count)
  );

endmodule

// File: tb/tb_na_be_wb_slave.sv
// Directed bench for na_be_wb_slave: register access, TX store-and-forward,
// RX packet accounting and irq, error cases and asynchronous reset.
module tb_na_be_wb_slave;
  import na_wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic [31:0] noc_out_flit;
  logic        noc_out_last;
  logic        noc_out_valid;
  logic        noc_out_ready;
  logic [31:0] noc_in_flit;
  logic        noc_in_last;
  logic        noc_in_valid;
  logic        noc_in_ready;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];  // {last, flit} expected on noc_out

  always #5 clk = ~clk;

  na_be_wb_slave dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wb_adr_i      (wb_adr_i),
    .wb_dat_i      (wb_dat_i),
    .wb_sel_i      (wb_sel_i),
    .wb_we_i       (wb_we_i),
    .wb_cyc_i      (wb_cyc_i),
    .wb_stb_i      (wb_stb_i),
    .wb_dat_o      (wb_dat_o),
    .wb_ack_o      (wb_ack_o),
    .wb_err_o      (wb_err_o),
    .noc_out_flit  (noc_out_flit),
    .noc_out_last  (noc_out_last),
    .noc_out_valid (noc_out_valid),
    .noc_out_ready (noc_out_ready),
    .noc_in_flit   (noc_in_flit),
    .noc_in_last   (noc_in_last),
    .noc_in_valid  (noc_in_valid),
    .noc_in_ready  (noc_in_ready),
    .irq           (irq)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One Wishbone classic access; returns the response seen #1 after its edge
  task automatic wb_xfer(input logic we, input logic [2:0] a, input logic [31:0] d,
                         output logic [31:0] rdat, output logic ack, output logic err);
    logic done;
    done     = 1'b0;
    ack      = 1'b0;
    err      = 1'b0;
    rdat     = '0;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = {27'd0, a, 2'b00};
    wb_dat_i = d;
    for (int i = 0; i < 8 && !done; i++) begin
      @(posedge clk);
      #1;
      if (wb_ack_o || wb_err_o) begin
        done = 1'b1;
        ack  = wb_ack_o;
        err  = wb_err_o;
        rdat = wb_dat_o;
      end
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    if (!done) check("wb_timeout", 0, 1);
  endtask

  task automatic wr(input string tag, input logic [2:0] a, input logic [31:0] d,
                    input logic exp_err);
    logic [31:0] r;
    logic ack, err;
    wb_xfer(1'b1, a, d, r, ack, err);
    check(tag, {ack, err}, exp_err ? 2'b01 : 2'b10);
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp_d,
                    input logic exp_err);
    logic [31:0] r;
    logic ack, err;
    wb_xfer(1'b0, a, 32'd0, r, ack, err);
    check({tag, "_rsp"}, {ack, err}, exp_err ? 2'b01 : 2'b10);
    check({tag, "_dat"}, r, exp_d);
  endtask

  task automatic push_flit(input logic [31:0] d, input logic last);
    noc_in_flit  = d;
    noc_in_last  = last;
    noc_in_valid = 1'b1;
    check("in_ready", noc_in_ready, 1);
    @(posedge clk);
    #1;
    noc_in_valid = 1'b0;
    noc_in_last  = 1'b0;
  endtask

  // Open the NoC output and compare every leaving flit with exp_q
  task automatic drain(input string tag);
    int n;
    int got;
    logic [32:0] e;
    n   = exp_q.size();
    got = 0;
    noc_out_ready = 1'b1;
    for (int c = 0; c < 100 && got < n; c++) begin
      @(negedge clk);
      if (noc_out_valid) begin
        e = exp_q.pop_front();
        check({tag, "_flit"}, noc_out_flit, e[31:0]);
        check({tag, "_last"}, noc_out_last, e[32]);
        got++;
      end
    end
    if (got < n) check({tag, "_timeout"}, got, n);
    @(posedge clk);
    #1;
    noc_out_ready = 1'b0;
    check({tag, "_idle"}, noc_out_valid, 0);
    exp_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ack"},   wb_ack_o, 0);
    check({tag, "_err"},   wb_err_o, 0);
    check({tag, "_dat"},   wb_dat_o, 0);
    check({tag, "_ovld"},  noc_out_valid, 0);
    check({tag, "_oflit"}, noc_out_flit, 0);
    check({tag, "_olast"}, noc_out_last, 0);
    check({tag, "_irdy"},  noc_in_ready, 0);
    check({tag, "_irq"},   irq, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] fill_last;
    logic [31:0] v;

    rst_n         = 1'b0;
    wb_adr_i      = '0;
    wb_dat_i      = '0;
    wb_sel_i      = 4'hF;
    wb_we_i       = 1'b0;
    wb_cyc_i      = 1'b0;
    wb_stb_i      = 1'b0;
    noc_out_ready = 1'b0;
    noc_in_flit   = '0;
    noc_in_last   = 1'b0;
    noc_in_valid  = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rd("txfree_rst", ADDR_TX_FREE, 32'd16, 1'b0);
    rd("rxstat_rst", ADDR_RX_STAT, 32'd0, 1'b0);
    rd("ctrl_rst",   ADDR_CTRL,    32'd0, 1'b0);

    // Errors before enabling: TX write disabled, bad address, wrong direction
    wr("txdata_dis", ADDR_TX_DATA, 32'h55, 1'b1);
    wr("addr6",      3'd6,         32'h0,  1'b1);
    rd("txdata_rd",  ADDR_TX_DATA, 32'd0,  1'b1);
    wr("rxstat_wr",  ADDR_RX_STAT, 32'h0,  1'b1);

    wr("ctrl_wr", ADDR_CTRL, 32'd3, 1'b0);
    rd("ctrl_rd", ADDR_CTRL, 32'd3, 1'b0);
    check("in_ready_en", noc_in_ready, 1);

    // TX store-and-forward: nothing leaves before the commit
    wr("tx_a0", ADDR_TX_DATA, 32'hA0, 1'b0);
    check("ovld_a0", noc_out_valid, 0);
    wr("tx_a1", ADDR_TX_DATA, 32'hA1, 1'b0);
    check("ovld_a1", noc_out_valid, 0);
    wr("tx_a2", ADDR_TX_LAST, 32'hA2, 1'b0);
    check("ovld_a2", noc_out_valid, 1);
    rd("txfree_a", ADDR_TX_FREE, 32'd13, 1'b0);
    exp_q.push_back({1'b0, 32'hA0});
    exp_q.push_back({1'b0, 32'hA1});
    exp_q.push_back({1'b1, 32'hA2});
    drain("pkt_a");

    // RX packet B0,B1 and irq
    push_flit(32'hB0, 1'b0);
    push_flit(32'hB1, 1'b1);
    check("irq_b_lag", irq, 0);
    @(posedge clk);
    #1;
    check("irq_b", irq, 1);
    rd("rxstat_b2", ADDR_RX_STAT, 32'h0001_0002, 1'b0);
    rd("rx_b0",     ADDR_RX_DATA, 32'hB0,        1'b0);
    rd("rxstat_b1", ADDR_RX_STAT, 32'h8001_0001, 1'b0);
    rd("rx_b1",     ADDR_RX_DATA, 32'hB1,        1'b0);
    rd("rxstat_b0", ADDR_RX_STAT, 32'h0000_0000, 1'b0);
    check("irq_b_fall", irq, 0);

    // Fill TX: 9 TX_DATA and 7 TX_LAST with the NoC stalled
    fill_last = 16'hD548;
    for (int i = 0; i < 16; i++) begin
      v = 32'h100 + 32'(i);
      wr("fill", fill_last[i] ? ADDR_TX_LAST : ADDR_TX_DATA, v, 1'b0);
      exp_q.push_back({fill_last[i], v});
    end
    rd("txfree_full", ADDR_TX_FREE, 32'd0, 1'b0);
    wr("tx_full_err", ADDR_TX_LAST, 32'h1FF, 1'b1);
    rd("rx_empty_err", ADDR_RX_DATA, 32'd0, 1'b1);
    drain("fill");

    // Max packet length: 10th TX_DATA refused, TX_LAST still accepted
    for (int i = 0; i < 9; i++) begin
      v = 32'h200 + 32'(i);
      wr("maxlen_data", ADDR_TX_DATA, v, 1'b0);
      exp_q.push_back({1'b0, v});
    end
    wr("maxlen_err", ADDR_TX_DATA, 32'h2FF, 1'b1);
    check("maxlen_novld", noc_out_valid, 0);
    wr("maxlen_last", ADDR_TX_LAST, 32'h209, 1'b0);
    exp_q.push_back({1'b1, 32'h209});
    check("maxlen_vld", noc_out_valid, 1);
    rd("txfree_max", ADDR_TX_FREE, 32'd6, 1'b0);
    drain("maxlen");

    // Simultaneous NoC push of a last flit and RX_DATA pop of a last flit
    push_flit(32'hC0, 1'b1);
    @(posedge clk);
    #1;
    check("irq_c", irq, 1);
    noc_in_flit  = 32'hC1;
    noc_in_last  = 1'b1;
    noc_in_valid = 1'b1;
    check("in_ready_c", noc_in_ready, 1);
    rd("simul_pop", ADDR_RX_DATA, 32'hC0, 1'b0);
    noc_in_valid = 1'b0;
    noc_in_last  = 1'b0;
    @(posedge clk);
    #1;
    check("irq_simul", irq, 1);
    rd("rxstat_simul", ADDR_RX_STAT, 32'h8001_0001, 1'b0);
    rd("rx_c1", ADDR_RX_DATA, 32'hC1, 1'b0);
    rd("rxstat_c0", ADDR_RX_STAT, 32'h0, 1'b0);
    check("irq_c_fall", irq, 0);

    // Asynchronous reset mid-packet with an access pending
    push_flit(32'hD0, 1'b1);
    wr("rst_e0", ADDR_TX_DATA, 32'hE0, 1'b0);
    wr("rst_e1", ADDR_TX_LAST, 32'hE1, 1'b0);
    wr("rst_e2", ADDR_TX_DATA, 32'hE2, 1'b0);
    check("pre_rst_irq",  irq, 1);
    check("pre_rst_ovld", noc_out_valid, 1);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = 1'b1;
    wb_adr_i = {27'd0, ADDR_TX_DATA, 2'b00};
    wb_dat_i = 32'hE3;
    #3;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("arst");
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("arst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rd("txfree_post", ADDR_TX_FREE, 32'd16, 1'b0);
    rd("rxstat_post", ADDR_RX_STAT, 32'd0,  1'b0);
    rd("ctrl_post",   ADDR_CTRL,    32'd0,  1'b0);
    check("ovld_post", noc_out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
